// File: rtl/bit_pattern_serializer.sv
// Parallel-to-serial pattern source for the 4-consecutive-1s detector.
// Accepts words over valid/ready and presents one bit per enabled clock on ain_out.
module bit_pattern_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ain_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             word_done,
  output logic [7:0]       word_cnt
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    bit_cnt;
  logic             last_bit;
  logic             accept;

  // Ready depends only on state, counter and shift_en, never on load_valid.
  assign last_bit   = (state == SHIFT) && (bit_cnt == LAST_IDX);
  assign load_ready = (state == IDLE) || (last_bit && shift_en);
  assign word_done  = last_bit && shift_en;
  assign accept     = load_valid && load_ready;

  // sreg keeps the presented bit at the outgoing end; ain_out mirrors it registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      sreg      <= '0;
      bit_cnt   <= '0;
      ain_out   <= IDLE_LEVEL;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      word_cnt  <= 8'd0;
    end else begin
      if (last_bit && shift_en) begin
        word_cnt <= word_cnt + 8'd1;
      end
      if (accept) begin
        state     <= SHIFT;
        sreg      <= data_in;
        bit_cnt   <= '0;
        ain_out   <= MSB_FIRST ? data_in[WIDTH-1] : data_in[0];
        bit_valid <= 1'b1;
        busy      <= 1'b1;
      end else if (state == SHIFT && shift_en) begin
        if (last_bit) begin
          state     <= IDLE;
          ain_out   <= IDLE_LEVEL;
          bit_valid <= 1'b0;
          busy      <= 1'b0;
        end else begin
          bit_cnt <= bit_cnt + CW'(1);
          if (MSB_FIRST) begin
            sreg    <= {sreg[WIDTH-2:0], 1'b0};
            ain_out <= sreg[WIDTH-2];
          end else begin
            sreg    <= {1'b0, sreg[WIDTH-1:1]};
            ain_out <= sreg[1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_pattern_serializer.sv
// Directed bench for bit_pattern_serializer: MSB-first and LSB-first instances share stimulus.
module tb_bit_pattern_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       shift_en;

  logic       load_ready, ain_out, bit_valid, busy, word_done;
  logic [7:0] word_cnt;
  logic       load_ready2, ain_out2, bit_valid2, busy2, word_done2;
  logic [7:0] word_cnt2;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_cnt;

  always #5 clk = ~clk;

  bit_pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready), .shift_en(shift_en), .ain_out(ain_out),
    .bit_valid(bit_valid), .busy(busy), .word_done(word_done), .word_cnt(word_cnt)
  );

  bit_pattern_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .load_valid(load_valid),
    .load_ready(load_ready2), .shift_en(shift_en), .ain_out(ain_out2),
    .bit_valid(bit_valid2), .busy(busy2), .word_done(word_done2), .word_cnt(word_cnt2)
  );

  // Move to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b1; data_in = 8'h00;
    tick(); tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests++;
      if (ain_out !== 1'b0 || bit_valid !== 1'b0 || load_ready !== 1'b1 ||
          word_cnt !== 8'd0 || busy !== 1'b0 || word_done !== 1'b0) begin
        fails++;
        $display("FAIL reset_idle cyc=%0d ain=%b bv=%b rdy=%b cnt=%0d busy=%b wd=%b (want 0 0 1 0 0 0)",
                 i, ain_out, bit_valid, load_ready, word_cnt, busy, word_done);
      end
      tick();
    end
    exp_cnt = 8'd0;
  endtask

  task automatic test_reset_mid_word();
    logic [7:0] w;
    data_in = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    #1;
    tests++;
    if (ain_out !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL midword_pre ain=%b busy=%b (want 1 1)", ain_out, busy);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    tests++;
    if (ain_out !== 1'b0 || busy !== 1'b0 || bit_valid !== 1'b0 || word_cnt !== exp_cnt ||
        load_ready !== 1'b1) begin
      fails++;
      $display("FAIL midword_reset ain=%b busy=%b bv=%b cnt=%0d rdy=%b (want 0 0 0 %0d 1)",
               ain_out, busy, bit_valid, word_cnt, load_ready, exp_cnt);
    end
    tick();
    // A fresh word after the abort goes through normally.
    w = 8'h3C;
    data_in = w; load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++;
      if (ain_out !== w[7-i] || bit_valid !== 1'b1 || word_done !== (i == 7)) begin
        fails++;
        $display("FAIL after_reset_word bit=%0d ain=%b bv=%b wd=%b (want %b 1 %b)",
                 i, ain_out, bit_valid, word_done, w[7-i], (i == 7));
      end
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++;
    if (word_cnt !== exp_cnt || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_reset_cnt cnt=%0d busy=%b (want %0d 0)", word_cnt, busy, exp_cnt);
    end
    tick();
  endtask

  task automatic test_f0();
    logic [7:0] exp_bits;
    int run, dets;
    exp_bits = 8'b1111_0000;
    run = 0; dets = 0;
    data_in = 8'hF0; load_valid = 1'b1; shift_en = 1'b1;
    #1;
    tests++;
    if (load_ready !== 1'b1) begin
      fails++;
      $display("FAIL f0_ready rdy=%b (want 1)", load_ready);
    end
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++;
      if (ain_out !== exp_bits[7-i] || bit_valid !== 1'b1 || busy !== 1'b1 ||
          word_done !== (i == 7)) begin
        fails++;
        $display("FAIL f0_bit bit=%0d ain=%b bv=%b busy=%b wd=%b (want %b 1 1 %b)",
                 i, ain_out, bit_valid, busy, word_done, exp_bits[7-i], (i == 7));
      end
      run = ain_out ? run + 1 : 0;
      if (run == 4) dets++;
      tick();
    end
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++;
    if (word_cnt !== exp_cnt || busy !== 1'b0 || bit_valid !== 1'b0 || ain_out !== 1'b0 ||
        load_ready !== 1'b1 || dets != 1) begin
      fails++;
      $display("FAIL f0_end cnt=%0d busy=%b bv=%b ain=%b rdy=%b dets=%0d (want %0d 0 0 0 1 1)",
               word_cnt, busy, bit_valid, ain_out, load_ready, dets, exp_cnt);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_msb, exp_lsb;
    int run1, run2, max1, max2;
    exp_msb = 16'b11111111_00001111;
    exp_lsb = 16'b11111111_11110000;
    run1 = 0; run2 = 0; max1 = 0; max2 = 0;
    data_in = 8'hFF; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 7) begin
        data_in = 8'h0F; load_valid = 1'b1;
      end
      if (i == 8) load_valid = 1'b0;
      #1;
      tests++;
      if (ain_out !== exp_msb[15-i] || ain_out2 !== exp_lsb[15-i] || bit_valid !== 1'b1 ||
          bit_valid2 !== 1'b1) begin
        fails++;
        $display("FAIL b2b_bit bit=%0d ain=%b ain_lsb=%b bv=%b bv_lsb=%b (want %b %b 1 1)",
                 i, ain_out, ain_out2, bit_valid, bit_valid2, exp_msb[15-i], exp_lsb[15-i]);
      end
      if (i == 3 || i == 7) begin
        tests++;
        if (load_ready !== (i == 7)) begin
          fails++;
          $display("FAIL b2b_ready bit=%0d rdy=%b (want %b)", i, load_ready, (i == 7));
        end
      end
      run1 = ain_out ? run1 + 1 : 0;
      run2 = ain_out2 ? run2 + 1 : 0;
      if (run1 > max1) max1 = run1;
      if (run2 > max2) max2 = run2;
      tick();
    end
    exp_cnt = exp_cnt + 8'd2;
    #1;
    tests++;
    if (word_cnt !== exp_cnt || bit_valid !== 1'b0 || max1 != 8 || max2 != 12) begin
      fails++;
      $display("FAIL b2b_end cnt=%0d bv=%b run_msb=%0d run_lsb=%0d (want %0d 0 8 12)",
               word_cnt, bit_valid, max1, max2, exp_cnt);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [10:0] exp_seq;
    exp_seq = 11'b1_0_1111_0_0_1_0_1;
    data_in = 8'hA5; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    load_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      shift_en = (i >= 2 && i < 5) ? 1'b0 : 1'b1;
      #1;
      tests++;
      if (ain_out !== exp_seq[10-i] || bit_valid !== 1'b1 || word_done !== (i == 10) ||
          load_ready !== (i == 10)) begin
        fails++;
        $display("FAIL stall_bit cyc=%0d ain=%b bv=%b wd=%b rdy=%b (want %b 1 %b %b)",
                 i, ain_out, bit_valid, word_done, load_ready, exp_seq[10-i], (i == 10), (i == 10));
      end
      tick();
    end
    shift_en = 1'b1;
    exp_cnt = exp_cnt + 8'd1;
    #1;
    tests++;
    if (word_cnt !== exp_cnt || busy !== 1'b0) begin
      fails++;
      $display("FAIL stall_end cnt=%0d busy=%b (want %0d 0)", word_cnt, busy, exp_cnt);
    end
    tick();
  endtask

  task automatic test_wrap();
    int dones, dones2;
    dones = 0; dones2 = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_in = 8'h01; load_valid = 1'b1; shift_en = 1'b1;
    tick();
    for (int c = 0; c < 2048; c++) begin
      if (c == 2047) load_valid = 1'b0;
      #1;
      if (c == 0) begin
        tests++;
        if (ain_out !== 1'b0 || ain_out2 !== 1'b1) begin
          fails++;
          $display("FAIL wrap_first ain_msb=%b ain_lsb=%b (want 0 1)", ain_out, ain_out2);
        end
      end
      if (c == 2040) begin
        tests++;
        if (word_cnt !== 8'd255 || word_cnt2 !== 8'd255) begin
          fails++;
          $display("FAIL wrap_255 cnt=%0d cnt_lsb=%0d (want 255 255)", word_cnt, word_cnt2);
        end
      end
      if (word_done === 1'b1) dones++;
      if (word_done2 === 1'b1) dones2++;
      tick();
    end
    #1;
    tests++;
    if (word_cnt !== 8'd0 || word_cnt2 !== 8'd0 || dones != 256 || dones2 != 256 ||
        busy !== 1'b0) begin
      fails++;
      $display("FAIL wrap_end cnt=%0d cnt_lsb=%0d dones=%0d dones_lsb=%0d busy=%b (want 0 0 256 256 0)",
               word_cnt, word_cnt2, dones, dones2, busy);
    end
    tick();
  endtask

  initial begin
    reset = 1'b1; load_valid = 1'b0; shift_en = 1'b0; data_in = 8'h00;
    tick();
    test_reset();
    test_reset_mid_word();
    test_f0();
    test_back_to_back();
    test_stall();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bit_pattern_serializer.md
Name: bit_pattern_serializer

Overview:
- Upstream stimulus stage for the 4-consecutive-1s detector.
- Accepts parallel pattern words over a valid/ready handshake and shifts them out one bit per clock on a serial line that drives the detector's serial input.
- Supports back-to-back words with no gap, stalling via a shift enable, and a transmitted-word counter.
- Gives lab benches and on-board demos a deterministic serial stream without hand-written per-bit stimulus.

Parameters:
- WIDTH, 8: bits per pattern word (legal range 2..32).
- MSB_FIRST, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- IDLE_LEVEL, 0: serial line level when no bit is being presented.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  pattern word to serialize.
- load_valid  input  1  data_in is valid; held until accepted.
- load_ready  output  1  serializer can accept a word this cycle.
- shift_en  input  1  1 = advance one bit per clock; 0 = hold the current bit.
- ain_out  output  1  serial bit stream to the detector's ain.
- bit_valid  output  1  ain_out carries a pattern bit this cycle.
- busy  output  1  a word is being shifted.
- word_done  output  1  one-cycle pulse while the final bit of a word is presented.
- word_cnt  output  8  number of fully transmitted words, modulo 256.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset values: state IDLE, ain_out = IDLE_LEVEL, bit_valid = 0, busy = 0, word_done = 0, word_cnt = 0, bit counter = 0, shift register = 0.
  - A reset asserted mid-word discards the word at the next edge.
  - No partial word is counted.
- States:
  - IDLE: load_ready = 1, bit_valid = 0, ain_out = IDLE_LEVEL.
  - SHIFT: busy = 1, bit_valid = 1.
- Accept rule: a word is accepted at a rising edge where load_valid = 1 and load_ready = 1.
  - data_in is captured into the shift register.
  - bit counter is cleared.
  - State becomes SHIFT.
- Latency: the first bit appears on ain_out in the cycle immediately after the accepting edge.
- Bit order: MSB_FIRST selects which end of the word is presented first. Bit k (k = 0..WIDTH-1) is presented in order.
- Advance rule in SHIFT:
  - At each edge with shift_en = 1, advance to the next bit.
  - With shift_en = 0, ain_out, the bit counter and the state hold.
  - bit_valid stays 1 while stalled.
- Last bit: while the bit counter = WIDTH-1, the following hold:
  - word_done = 1 for one cycle only if shift_en = 1; it stays 0 while stalled.
  - load_ready = shift_en. This is combinational from state, counter and shift_en.
- End of word: at the edge leaving the last bit with shift_en = 1:
  - word_cnt increments, wrapping 255 -> 0.
  - If a new word is accepted at that same edge, its first bit follows with no gap and the state stays SHIFT.
  - Otherwise the state returns to IDLE and ain_out = IDLE_LEVEL.
- Handshake during SHIFT (not last bit): load_ready = 0. load_valid is ignored, and data_in must not change while load_valid = 1.
- shift_en in IDLE has no effect; acceptance does not depend on shift_en.
- Reset has priority over acceptance and shifting when both occur at the same edge.
- No combinational path from load_valid to load_ready.

Test Plan:
- Reset release, no load_valid for 10 cycles -> ain_out = 0, bit_valid = 0, load_ready = 1, word_cnt = 0 throughout.
- Load 8'hF0, MSB_FIRST = 1, shift_en = 1 -> ain_out = 1,1,1,1,0,0,0,0 on the 8 cycles after acceptance.
  - word_done high on the 8th bit only.
  - word_cnt = 1, then IDLE.
  - Downstream detector yout asserts once.
- Back-to-back 8'hFF then 8'h0F, load_valid held -> second word accepted on the last-bit edge.
  - 16 contiguous bit_valid cycles with 12 consecutive 1s.
  - word_cnt = 2.
- Load 8'hA5, shift_en = 0 for 3 cycles on bit 2 -> bit 2 value (1) held 4 cycles.
  - Stream completes as 1,0,1,0,0,1,0,1.
  - word_done delayed by exactly 3 cycles.
- Reset asserted on bit 4 of 8'hFF -> next cycle ain_out = 0, busy = 0, word_cnt unchanged.
  - A new word is accepted normally afterwards.
- 256 words of 8'h01 -> word_cnt wraps to 0 after the 256th word_done.
  - MSB_FIRST = 0 instance emits 1 first.
